// File: rtl/pipe_pkg.sv
// pipe_pkg: constants, sizing helpers and the redirect-tagged entry type shared
// by every inter-stage pipeline buffer (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
package pipe_pkg;

  // Largest supported buffer depth; sizes the occupancy port of every stage.
  localparam int PIPE_MAX_DEPTH     = 4;
  localparam int PIPE_DEF_PAYLOAD_W = 64;
  localparam int PIPE_CNT_PORT_W    = 3;

  // Ceiling log2, usable in constant expressions.
  function automatic int pipe_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Bits needed to hold an occupancy of 0..depth.
  function automatic int pipe_occ_w(input int depth);
    return pipe_clog2(depth + 1);
  endfunction

  // Bits needed for a pointer into depth entries; never less than one bit.
  function automatic int pipe_ptr_w(input int depth);
    return (depth > 1) ? pipe_clog2(depth) : 1;
  endfunction

  // Stage-buffer entry at the default payload width. Buffers built with a
  // different payload width declare the same {redir, payload} shape locally.
  typedef struct packed {
    logic                          redir;
    logic [PIPE_DEF_PAYLOAD_W-1:0] payload;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: pointer, occupancy and redirect-kill bookkeeping for
// pipe_stage_buf. The storage array itself lives in the parent.
// Optional macro PIPE_STAGE_BUF_PERF_EN adds o_drop_num for drop accounting.
module pipe_stage_ctrl
  import pipe_pkg::*;
#(
  parameter  int DEPTH         = 1,
  parameter  int KILL_ON_REDIR = 1,
  localparam int PTR_W         = pipe_ptr_w(DEPTH),
  localparam int CNT_W         = pipe_occ_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  input  logic             i_out_ready,
  input  logic             i_head_redir,
  input  logic             i_flush,
  output logic             o_in_ready,
  output logic             o_out_valid,
  output logic             o_wr_en,
  output logic [PTR_W-1:0] o_wptr,
  output logic [PTR_W-1:0] o_rptr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_kill
`ifdef PIPE_STAGE_BUF_PERF_EN
  ,
  output logic [2:0]       o_drop_num
`endif
);

  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic             r_kill;

  logic             w_inReady;
  logic             w_outValid;
  logic             w_push;
  logic             w_pop;
  logic             w_killEvt;
  logic [CNT_W-1:0] w_countNext;
  logic [PTR_W-1:0] w_wptrNext;
  logic [PTR_W-1:0] w_rptrNext;
  logic             w_killNext;
`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [2:0]       w_dropNum;
`endif

  // Circular pointer advance, wrapping DEPTH-1 back to 0.
  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake decode: a single-entry buffer may accept while its head leaves,
  // deeper buffers only look at their own occupancy so ready stays off the
  // downstream combinational path.
  always_comb begin
    w_outValid = (r_count != '0);
    if (DEPTH == 1) begin
      w_inReady = !w_outValid || i_out_ready;
    end else begin
      w_inReady = (r_count < CNT_W'(DEPTH));
    end
    w_push    = i_in_valid && w_inReady;
    w_pop     = w_outValid && i_out_ready;
    w_killEvt = (KILL_ON_REDIR != 0) && !i_flush && w_pop && i_head_redir;
  end

  // Next-state selection: flush beats redirect kill beats ordinary traffic.
  always_comb begin
    w_countNext = r_count;
    w_wptrNext  = r_wptr;
    w_rptrNext  = r_rptr;
    w_killNext  = 1'b0;
`ifdef PIPE_STAGE_BUF_PERF_EN
    w_dropNum   = '0;
`endif
    if (i_flush) begin
      w_countNext = '0;
      w_wptrNext  = '0;
      w_rptrNext  = '0;
`ifdef PIPE_STAGE_BUF_PERF_EN
      w_dropNum   = 3'(r_count) - 3'(w_pop) + 3'(w_push);
`endif
    end else if (w_killEvt) begin
      w_countNext = '0;
      w_wptrNext  = '0;
      w_rptrNext  = '0;
      w_killNext  = (r_count > CNT_W'(1)) || w_push;
`ifdef PIPE_STAGE_BUF_PERF_EN
      w_dropNum   = 3'(r_count) - 3'd1 + 3'(w_push);
`endif
    end else begin
      if (w_push) w_wptrNext = ptrInc(r_wptr);
      if (w_pop)  w_rptrNext = ptrInc(r_rptr);
      if (w_push && !w_pop) begin
        w_countNext = r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        w_countNext = r_count - CNT_W'(1);
      end
    end
  end

  // Bookkeeping registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_kill  <= 1'b0;
    end else begin
      r_count <= w_countNext;
      r_wptr  <= w_wptrNext;
      r_rptr  <= w_rptrNext;
      r_kill  <= w_killNext;
    end
  end

  assign o_in_ready  = w_inReady;
  assign o_out_valid = w_outValid;
  assign o_wr_en     = w_push && !i_flush && !w_killEvt;
  assign o_wptr      = r_wptr;
  assign o_rptr      = r_rptr;
  assign o_count     = r_count;
  assign o_kill      = r_kill;
`ifdef PIPE_STAGE_BUF_PERF_EN
  assign o_drop_num  = w_dropNum;
`endif

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: parametrised valid/ready inter-stage buffer (1..4 entries)
// carrying a payload plus redirect flag, with flush and redirect-kill.
// Optional macro PIPE_STAGE_BUF_PERF_EN adds stall/bubble/drop counters.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W     = 64,
  parameter int DEPTH         = 1,
  parameter int KILL_ON_REDIR = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PAYLOAD_W-1:0]       in_data,
  input  logic                       in_redir,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PAYLOAD_W-1:0]       out_data,
  output logic                       out_redir,
  input  logic                       flush_i,
  output logic                       kill_o,
  output logic [PIPE_CNT_PORT_W-1:0] count_o
`ifdef PIPE_STAGE_BUF_PERF_EN
  ,
  output logic [31:0]                stall_cnt_o,
  output logic [31:0]                bubble_cnt_o,
  output logic [15:0]                drop_cnt_o
`endif
);

  localparam int PTR_W = pipe_ptr_w(DEPTH);
  localparam int CNT_W = pipe_occ_w(DEPTH);

  typedef struct packed {
    logic                 redir;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t           r_mem [DEPTH];
  entry_t           w_head;
  logic             w_wrEn;
  logic [PTR_W-1:0] w_wptr;
  logic [PTR_W-1:0] w_rptr;
  logic [CNT_W-1:0] w_count;
`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [2:0]       w_dropNum;
  logic [16:0]      w_dropSum;
  logic [31:0]      r_stallCnt;
  logic [31:0]      r_bubbleCnt;
  logic [15:0]      r_dropCnt;
`endif

  pipe_stage_ctrl #(
    .DEPTH        (DEPTH),
    .KILL_ON_REDIR(KILL_ON_REDIR)
  ) u_ctrl (
    .clk         (clk),
    .rst_n       (reset),
    .i_in_valid  (in_valid),
    .i_out_ready (out_ready),
    .i_head_redir(w_head.redir),
    .i_flush     (flush_i),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .o_wr_en     (w_wrEn),
    .o_wptr      (w_wptr),
    .o_rptr      (w_rptr),
    .o_count     (w_count),
    .o_kill      (kill_o)
`ifdef PIPE_STAGE_BUF_PERF_EN
    ,
    .o_drop_num  (w_dropNum)
`endif
  );

  // Entry storage: an accepted, surviving beat lands at the write pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wrEn) begin
      r_mem[w_wptr] <= '{redir: in_redir, payload: in_data};
    end
  end

  // Head outputs come straight from storage, never from the in_* inputs.
  always_comb begin
    w_head    = r_mem[w_rptr];
    out_data  = w_head.payload;
    out_redir = w_head.redir;
    count_o   = PIPE_CNT_PORT_W'(w_count);
  end

`ifdef PIPE_STAGE_BUF_PERF_EN
  // Saturating drop accumulation needs one spare bit to detect overflow.
  always_comb begin
    w_dropSum = {1'b0, r_dropCnt} + 17'(w_dropNum);
  end

  // Saturating performance counters for stalls, bubbles and discarded beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stallCnt  <= '0;
      r_bubbleCnt <= '0;
      r_dropCnt   <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + 32'd1;
      if (!out_valid && (r_bubbleCnt != '1)) r_bubbleCnt <= r_bubbleCnt + 32'd1;
      r_dropCnt <= w_dropSum[16] ? '1 : w_dropSum[15:0];
    end
  end

  assign stall_cnt_o  = r_stallCnt;
  assign bubble_cnt_o = r_bubbleCnt;
  assign drop_cnt_o   = r_dropCnt;
`endif

endmodule
